// File: rtl/arith_encoder_pkg.sv
// Shared definitions for the arithmetic encoder back end: carry-resolver
// states, the run byte value and the byte/run width defaults.
package arith_encoder_pkg;

    localparam int BYTE_WIDTH_DEF = 8;
    localparam int RUN_WIDTH_DEF  = 16;
    localparam int CARRY_BIT      = BYTE_WIDTH_DEF;
    localparam logic [BYTE_WIDTH_DEF-1:0] RUN_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_EMPTY      = 3'd0,
        ST_HOLD       = 3'd1,
        ST_EMIT_PEND  = 3'd2,
        ST_EMIT_RUN   = 3'd3,
        ST_FLUSH_PEND = 3'd4,
        ST_FLUSH_RUN  = 3'd5
    } state_t;

    function automatic logic is_emit_state(input state_t st);
        case (st)
            ST_EMIT_PEND, ST_EMIT_RUN, ST_FLUSH_PEND, ST_FLUSH_RUN: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arith_carry_resolver.sv
// Resolves carries over runs of 0xFF pre-carry bytes and emits final
// bitstream bytes on a valid/ready port; a flush drains and tags the last byte.
module arith_carry_resolver
    import arith_encoder_pkg::*;
#(
    parameter int GENERAL_BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter int GENERAL_RUN_WIDTH  = RUN_WIDTH_DEF
) (
    input  logic                          general_clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [GENERAL_BYTE_WIDTH:0]   in_data,
    input  logic                          in_flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [GENERAL_BYTE_WIDTH-1:0] out_byte,
    output logic                          out_last,
    output logic                          flush_done,
    output logic                          err
);

    localparam int BW = GENERAL_BYTE_WIDTH;
    localparam int RW = GENERAL_RUN_WIDTH;
    localparam logic [BW:0]   RUN_WORD = {1'b0, {BW{1'b1}}};
    localparam logic [RW-1:0] RUN_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] RUN_ONE  = {{(RW-1){1'b0}}, 1'b1};

    state_t          state_r, state_s;
    logic [BW-1:0]   pending_r, pending_s;
    logic [BW-1:0]   new_r, new_s;
    logic            carry_r, carry_s;
    logic [RW-1:0]   run_r, run_s;
    logic            flush_r, flush_s;
    logic            err_r, err_s;
    logic            flush_done_r, flush_done_s;
    logic            out_valid_r, out_valid_s;
    logic [BW-1:0]   out_byte_r, out_byte_s;
    logic            out_last_r, out_last_s;
    logic            in_ready_s;
    logic            accept_s;

    // A latched flush closes the input port until the flush has been started.
    assign in_ready_s = ~reset & ((state_r == ST_EMPTY) | ((state_r == ST_HOLD) & ~flush_r));
    assign accept_s   = in_valid & in_ready_s;

    // Next-state and datapath update for the resolver FSM.
    always_comb begin
        state_s      = state_r;
        pending_s    = pending_r;
        new_s        = new_r;
        carry_s      = carry_r;
        run_s        = run_r;
        flush_s      = flush_r;
        err_s        = err_r;
        flush_done_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    pending_s = in_data[BW-1:0];
                    flush_s   = in_flush;
                    err_s     = err_r | in_data[BW];
                    state_s   = ST_HOLD;
                end else if (in_flush & in_ready_s) begin
                    flush_done_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (flush_r) begin
                    flush_s = 1'b0;
                    carry_s = 1'b0;
                    state_s = ST_FLUSH_PEND;
                end else if (accept_s) begin
                    flush_s = in_flush;
                    if (in_data == RUN_WORD) begin
                        if (&run_r) begin
                            err_s = 1'b1;
                        end else begin
                            run_s = run_r + RUN_ONE;
                        end
                    end else begin
                        carry_s = in_data[BW];
                        new_s   = in_data[BW-1:0];
                        // A carry into an all-ones pending byte has nowhere to go.
                        err_s   = err_r | (in_data[BW] & (&pending_r));
                        state_s = ST_EMIT_PEND;
                    end
                end else if (in_flush) begin
                    carry_s = 1'b0;
                    state_s = ST_FLUSH_PEND;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_EMIT_PEND: begin
                if (!out_ready) begin
                    state_s = ST_EMIT_PEND;
                end else if (run_r != RUN_ZERO) begin
                    state_s = ST_EMIT_RUN;
                end else begin
                    pending_s = new_r;
                    state_s   = ST_HOLD;
                end
            end
            ST_EMIT_RUN: begin
                if (!out_ready) begin
                    state_s = ST_EMIT_RUN;
                end else if (run_r == RUN_ONE) begin
                    run_s     = RUN_ZERO;
                    pending_s = new_r;
                    state_s   = ST_HOLD;
                end else begin
                    run_s = run_r - RUN_ONE;
                end
            end
            ST_FLUSH_PEND: begin
                if (!out_ready) begin
                    state_s = ST_FLUSH_PEND;
                end else if (run_r != RUN_ZERO) begin
                    state_s = ST_FLUSH_RUN;
                end else begin
                    flush_done_s = 1'b1;
                    state_s      = ST_EMPTY;
                end
            end
            ST_FLUSH_RUN: begin
                if (!out_ready) begin
                    state_s = ST_FLUSH_RUN;
                end else if (run_r == RUN_ONE) begin
                    run_s        = RUN_ZERO;
                    flush_done_s = 1'b1;
                    state_s      = ST_EMPTY;
                end else begin
                    run_s = run_r - RUN_ONE;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state so they register cleanly.
    always_comb begin
        out_valid_s = is_emit_state(state_s);
        out_byte_s  = {BW{1'b0}};
        out_last_s  = 1'b0;
        case (state_s)
            ST_EMIT_PEND: begin
                out_byte_s = pending_s + {{(BW-1){1'b0}}, carry_s};
            end
            ST_FLUSH_PEND: begin
                out_byte_s = pending_s;
                out_last_s = (run_s == RUN_ZERO);
            end
            ST_EMIT_RUN: begin
                out_byte_s = carry_s ? {BW{1'b0}} : {BW{1'b1}};
            end
            ST_FLUSH_RUN: begin
                out_byte_s = {BW{1'b1}};
                out_last_s = (run_s == RUN_ONE);
            end
            default: begin
                out_byte_s = {BW{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers; reset discards any stream in flight.
    always_ff @(posedge general_clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_EMPTY;
            pending_r    <= {BW{1'b0}};
            new_r        <= {BW{1'b0}};
            carry_r      <= 1'b0;
            run_r        <= RUN_ZERO;
            flush_r      <= 1'b0;
            err_r        <= 1'b0;
            flush_done_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_byte_r   <= {BW{1'b0}};
            out_last_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            pending_r    <= pending_s;
            new_r        <= new_s;
            carry_r      <= carry_s;
            run_r        <= run_s;
            flush_r      <= flush_s;
            err_r        <= err_s;
            flush_done_r <= flush_done_s;
            out_valid_r  <= out_valid_s;
            out_byte_r   <= out_byte_s;
            out_last_r   <= out_last_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_byte   = out_byte_r;
    assign out_last   = out_last_r;
    assign flush_done = flush_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_arith_carry_resolver.sv
// Scoreboard bench for arith_carry_resolver: a big-number carry model feeds an
// expectation queue that a free-running monitor drains on every output handshake.
module tb_arith_carry_resolver;
    import arith_encoder_pkg::*;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_flush = 1'b0;
    logic [8:0] in_data = 9'h000;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, flush_done, err;
    logic [7:0] out_byte;

    logic       v2 = 1'b0;
    logic       f2 = 1'b0;
    logic [8:0] d2 = 9'h000;
    logic       rdy2, ov2, ol2, fd2, err2;
    logic [7:0] ob2;

    int errors = 0;
    int checks = 0;

    logic [7:0] held[$];
    exp_t       exp_q[$];
    bit         exp_err = 1'b0;
    int         exp_fd = 0;
    int         fd_cnt = 0;
    int         hs_cnt = 0;
    int         cyc = 0;
    int         stall_until = 0;
    bit         rnd_ready = 1'b0;

    always #5 clk = ~clk;

    arith_carry_resolver dut (
        .general_clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
        .flush_done(flush_done), .err(err)
    );

    arith_carry_resolver #(.GENERAL_BYTE_WIDTH(8), .GENERAL_RUN_WIDTH(2)) dut2 (
        .general_clk(clk), .reset(reset),
        .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_flush(f2),
        .out_valid(ov2), .out_ready(1'b1), .out_byte(ob2), .out_last(ol2),
        .flush_done(fd2), .err(err2)
    );

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: held bytes form a big-endian number; a carry is added with ripple.
    function automatic void model_word(input logic [8:0] w);
        logic [8:0] sum;
        logic       c;
        exp_t       e;
        if (held.size() == 0) begin
            held.push_back(w[7:0]);
            exp_err |= w[CARRY_BIT];
        end else if (w == {1'b0, RUN_BYTE}) begin
            held.push_back(RUN_BYTE);
        end else begin
            c = w[CARRY_BIT];
            for (int i = held.size() - 1; i >= 0; i--) begin
                sum = {1'b0, held[i]} + {8'h00, c};
                held[i] = sum[7:0];
                c = sum[8];
            end
            if (c) exp_err = 1'b1;
            foreach (held[i]) begin
                e.b = held[i];
                e.last = 1'b0;
                exp_q.push_back(e);
            end
            held.delete();
            held.push_back(w[7:0]);
        end
    endfunction

    function automatic void model_flush();
        exp_t e;
        foreach (held[i]) begin
            e.b = held[i];
            e.last = (i == held.size() - 1);
            exp_q.push_back(e);
        end
        held.delete();
        exp_fd++;
    endfunction

    // Ready generator: optional random back-pressure plus directed stall windows.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < stall_until) out_ready = 1'b0;
            else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    // Monitor: pops and compares on each handshake, checks stability under stall.
    initial begin
        logic       prev_v, prev_r, prev_l;
        logic [7:0] prev_b;
        exp_t       e;
        prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_b = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (prev_v && !prev_r) begin
                    check_eq("stall_valid", out_valid, 1'b1);
                    check_eq("stall_byte", out_byte, prev_b);
                    check_eq("stall_last", out_last, prev_l);
                end
                if (out_valid) check_eq("in_ready_during_drain", in_ready, 1'b0);
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    check_eq("byte_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("out_byte", out_byte, e.b);
                        check_eq("out_last", out_last, e.last);
                    end
                end
                if (flush_done) fd_cnt++;
                prev_v = out_valid; prev_r = out_ready; prev_b = out_byte; prev_l = out_last;
            end
        end
    end

    task automatic send_op(input logic [8:0] w, input bit v, input bit fl);
        int t;
        in_valid = v; in_data = w; in_flush = fl;
        if (v) model_word(w);
        if (fl) model_flush();
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_eq("accept_in_time", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || fd_cnt != exp_fd) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check_eq({name, "_all_bytes_out"}, exp_q.size(), 32'd0);
        check_eq({name, "_flush_done_count"}, fd_cnt, exp_fd);
        check_eq({name, "_err"}, err, exp_err);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("reset_out_valid", out_valid, 1'b0);
        check_eq("reset_in_ready", in_ready, 1'b0);
        held.delete(); exp_q.delete(); exp_err = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_out_byte", out_byte, 8'h00);
        check_eq("reset_out_last", out_last, 1'b0);
        check_eq("reset_flush_done", flush_done, 1'b0);
        check_eq("reset_err", err, 1'b0);
        #2 reset = 1'b0;
        #1 check_eq("in_ready_after_reset", in_ready, 1'b1);
        exp_fd = fd_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [8:0] w, input bit v, input bit fl);
        int t;
        v2 = v; d2 = w; f2 = fl;
        t = 0;
        @(negedge clk);
        while (!rdy2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("dut2_accept_in_time", rdy2, 1'b1);
        @(posedge clk);
        #1;
        v2 = 1'b0; f2 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] w;
        logic [7:0] got_b[$];
        logic       got_l[$];
        int         base, t, n;

        @(posedge clk);
        #1;
        do_reset();

        // Plain stream, no carries.
        send_op(9'h012, 1'b1, 1'b0);
        send_op(9'h034, 1'b1, 1'b0);
        send_op(9'h000, 1'b0, 1'b1);
        drain("plain");

        // Carry ripples through two run bytes.
        send_op(9'h012, 1'b1, 1'b0);
        send_op(9'h0FF, 1'b1, 1'b0);
        send_op(9'h0FF, 1'b1, 1'b0);
        send_op(9'h105, 1'b1, 1'b0);
        send_op(9'h000, 1'b0, 1'b1);
        drain("carry_run");

        // Runs released unchanged without a carry.
        send_op(9'h012, 1'b1, 1'b0);
        send_op(9'h0FF, 1'b1, 1'b0);
        send_op(9'h0FF, 1'b1, 1'b0);
        send_op(9'h040, 1'b1, 1'b0);
        send_op(9'h000, 1'b0, 1'b1);
        drain("no_carry_run");

        // Back-pressure in the middle of a carried run.
        base = hs_cnt;
        fork
            begin
                send_op(9'h012, 1'b1, 1'b0);
                send_op(9'h0FF, 1'b1, 1'b0);
                send_op(9'h0FF, 1'b1, 1'b0);
                send_op(9'h105, 1'b1, 1'b0);
                send_op(9'h000, 1'b0, 1'b1);
            end
            begin
                t = 0;
                while (hs_cnt < base + 2 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                stall_until = cyc + 5;
            end
        join
        drain("stall");

        // Random streams under random back-pressure.
        rnd_ready = 1'b1;
        for (int s = 0; s < 30; s++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) < 4) w = {1'b0, RUN_BYTE};
                else w = 9'($urandom_range(0, 511));
                send_op(w, 1'b1, (k == n - 1) && ($urandom_range(0, 1) == 1));
            end
            if (held.size() != 0) send_op(9'h000, 1'b0, 1'b1);
            if (s % 7 == 0) send_op(9'h000, 1'b0, 1'b1);
        end
        rnd_ready = 1'b0;
        drain("random");

        // Carry arriving with no pending byte is dropped and flagged.
        do_reset();
        send_op(9'h101, 1'b1, 1'b0);
        send_op(9'h000, 1'b0, 1'b1);
        drain("carry_in_empty");

        // Reset while emitting a run, then a fresh stream.
        do_reset();
        send_op(9'h012, 1'b1, 1'b0);
        send_op(9'h0FF, 1'b1, 1'b0);
        send_op(9'h0FF, 1'b1, 1'b0);
        base = hs_cnt;
        send_op(9'h105, 1'b1, 1'b0);
        t = 0;
        while (hs_cnt < base + 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        stall_until = cyc + 100000;
        repeat (3) @(negedge clk);
        check_eq("run_emitting_before_reset", out_valid, 1'b1);
        @(posedge clk);
        #1;
        do_reset();
        stall_until = 0;
        send_op(9'h0AA, 1'b1, 1'b0);
        send_op(9'h000, 1'b0, 1'b1);
        drain("after_mid_reset");

        // Narrow run counter saturates at 3 and flags.
        check_eq("dut2_err_clear", err2, 1'b0);
        send2(9'h012, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send2(9'h0FF, 1'b1, 1'b0);
        check_eq("dut2_run_saturate_err", err2, 1'b1);
        send2(9'h000, 1'b0, 1'b1);
        t = 0;
        while (t < 30) begin
            @(negedge clk);
            t++;
            if (ov2) begin
                got_b.push_back(ob2);
                got_l.push_back(ol2);
                if (ol2) break;
            end
        end
        check_eq("dut2_byte_count", got_b.size(), 32'd4);
        if (got_b.size() == 4) begin
            check_eq("dut2_byte0", got_b[0], 8'h12);
            for (int k = 1; k < 4; k++) check_eq("dut2_run_byte", got_b[k], 8'hFF);
            check_eq("dut2_last_only_at_end", {got_l[0], got_l[1], got_l[2], got_l[3]}, 4'b0001);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
